// File: rtl/piso_param_ser.sv
// Parametrised PISO shifter with valid/ready load, per-frame direction, stall and framing flags.
// Optional parity bit appended after the data bits when PISO_PARITY_EN is defined.
module piso_param_ser #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b1,
  parameter bit   PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_mode,
  input  logic             shift_en,
  output logic             qout,
  output logic             qout_bar,
  output logic             busy,
  output logic             last
);

`ifdef PISO_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int CW = $clog2(FLEN);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Frame laid out in transmit order: bit 0 goes on the wire first.
  function automatic logic [FLEN-1:0] build_frame(input logic [WIDTH-1:0] d,
                                                  input logic             lsb_first);
    logic [FLEN-1:0] f;
    f = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (lsb_first) begin
        f[i] = d[i];
      end else begin
        f[i] = d[WIDTH-1-i];
      end
    end
`ifdef PISO_PARITY_EN
    f[WIDTH] = (^d) ^ PARITY_ODD;
`endif
    return f;
  endfunction

  state_e          state_q, state_d;
  logic [FLEN-1:0] sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            qout_q, qout_d;
  logic            qout_bar_q;
  logic            busy_q, busy_d;
  logic            last_q, last_d;
  logic            accept_s;
  logic            end_s;
  logic [FLEN-1:0] frame_s;

  assign load_ready = rst && ((state_q == ST_IDLE) || (last_q && shift_en));
  assign accept_s   = load_valid && load_ready;
  assign end_s      = (state_q == ST_SHIFT) && last_q && shift_en;
  assign frame_s    = build_frame(din, shift_mode);

  assign qout     = qout_q;
  assign qout_bar = qout_bar_q;
  assign busy     = busy_q;
  assign last     = last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      qout_q     <= IDLE_LEVEL;
      qout_bar_q <= ~IDLE_LEVEL;
      busy_q     <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      qout_q     <= qout_d;
      qout_bar_q <= ~qout_d;
      busy_q     <= busy_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (end_s && !accept_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A load during the last bit takes priority over returning to idle.
  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    qout_d = qout_q;
    busy_d = busy_q;
    last_d = last_q;
    if (accept_s) begin
      qout_d = frame_s[0];
      sr_d   = frame_s >> 1;
      cnt_d  = CW'(FLEN - 1);
      busy_d = 1'b1;
      last_d = 1'b0;
    end else if (end_s) begin
      sr_d   = '0;
      cnt_d  = '0;
      qout_d = IDLE_LEVEL;
      busy_d = 1'b0;
      last_d = 1'b0;
    end else if ((state_q == ST_SHIFT) && shift_en) begin
      qout_d = sr_q[0];
      sr_d   = sr_q >> 1;
      cnt_d  = cnt_q - CW'(1);
      last_d = (cnt_q == CW'(1));
    end else begin
      sr_d   = sr_q;
      cnt_d  = cnt_q;
    end
  end

endmodule

// File: tb/tb_piso_param_ser.sv
// Directed self-checking bench for piso_param_ser (default parameters).
// Parity scenario runs only when PISO_PARITY_EN is defined.
module tb_piso_param_ser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = 8'h00;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic       shift_mode = 1'b0;
  logic       shift_en = 1'b0;
  logic       qout;
  logic       qout_bar;
  logic       busy;
  logic       last;

  int errors = 0;
  int checks = 0;

  piso_param_ser #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .shift_mode(shift_mode),
    .shift_en  (shift_en),
    .qout      (qout),
    .qout_bar  (qout_bar),
    .busy      (busy),
    .last      (last)
  );

  always #5 clk = ~clk;

  task test_reset;
    rst = 1'b0; load_valid = 1'b1; din = 8'h55; shift_mode = 1'b0; shift_en = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (qout !== 1'b1) begin errors++; $display("FAIL reset_qout: got %b expected 1", qout); end
    checks++; if (qout_bar !== 1'b0) begin errors++; $display("FAIL reset_qout_bar: got %b expected 0", qout_bar); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", last); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", load_ready); end
    rst = 1'b1; load_valid = 1'b0;
    @(negedge clk);
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", load_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy: got %b expected 0", busy); end
    checks++; if (qout !== 1'b1) begin errors++; $display("FAIL release_qout: got %b expected 1", qout); end
  endtask

  task test_msb_first;
    logic [7:0] v;
    logic       eb;
    logic       el;
    v = 8'h2D;
    din = v; shift_mode = 1'b0; load_valid = 1'b1; shift_en = 1'b1;
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL msb_ready_idle: got %b expected 1", load_ready); end
    @(negedge clk);
    load_valid = 1'b0; din = 8'hC3; shift_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      eb = v[7-i];
      el = (i == 7);
      checks++; if (qout !== eb) begin errors++; $display("FAIL msb_bit%0d: got %b expected %b", i, qout, eb); end
      checks++; if (qout_bar !== ~eb) begin errors++; $display("FAIL msb_bar%0d: got %b expected %b", i, qout_bar, ~eb); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL msb_busy%0d: got %b expected 1", i, busy); end
      checks++; if (last !== el) begin errors++; $display("FAIL msb_last%0d: got %b expected %b", i, last, el); end
      @(negedge clk);
    end
    checks++; if (qout !== 1'b1) begin errors++; $display("FAIL msb_idle_qout: got %b expected 1", qout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL msb_idle_busy: got %b expected 0", busy); end
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL msb_idle_last: got %b expected 0", last); end
  endtask

  task test_lsb_stall;
    logic [9:0] exp_q;
    logic [9:0] en_tab;
    logic       el;
    int         busy_cnt;
    exp_q  = 10'b0010111101;   // cycle i expectation is bit i
    en_tab = 10'b1111110011;
    busy_cnt = 0;
    din = 8'h2D; shift_mode = 1'b1; load_valid = 1'b1; shift_en = 1'b1;
    @(negedge clk);
    din = 8'h00; shift_mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      shift_en   = en_tab[i];
      load_valid = (i < 6);
      el = (i == 9);
      if (i < 6) begin
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL lsb_ready_busy%0d: got %b expected 0", i, load_ready); end
      end
      checks++; if (qout !== exp_q[i]) begin errors++; $display("FAIL lsb_bit%0d: got %b expected %b", i, qout, exp_q[i]); end
      checks++; if (last !== el) begin errors++; $display("FAIL lsb_last%0d: got %b expected %b", i, last, el); end
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
    end
    load_valid = 1'b0; shift_en = 1'b1;
    if (busy === 1'b1) busy_cnt++;
    checks++; if (busy_cnt != 10) begin errors++; $display("FAIL lsb_busy_cycles: got %0d expected 10", busy_cnt); end
    checks++; if (qout !== 1'b1) begin errors++; $display("FAIL lsb_idle_qout: got %b expected 1", qout); end
  endtask

  task test_back_to_back;
    logic er;
    logic eb;
    din = 8'hFF; shift_mode = 1'b0; load_valid = 1'b1; shift_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      load_valid = (i == 7);
      din = (i == 7) ? 8'h00 : 8'hA5;
      er = (i == 7) || (i == 15);
      eb = (i < 8);
      checks++; if (load_ready !== er) begin errors++; $display("FAIL b2b_ready%0d: got %b expected %b", i, load_ready, er); end
      checks++; if (qout !== eb) begin errors++; $display("FAIL b2b_bit%0d: got %b expected %b", i, qout, eb); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy%0d: got %b expected 1", i, busy); end
      checks++; if (last !== er) begin errors++; $display("FAIL b2b_last%0d: got %b expected %b", i, last, er); end
      @(negedge clk);
    end
    load_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b expected 0", busy); end
    checks++; if (qout !== 1'b1) begin errors++; $display("FAIL b2b_idle_qout: got %b expected 1", qout); end
  endtask

  task test_reset_mid_frame;
    logic [7:0] v;
    logic       eb;
    v = 8'hA5;
    din = v; shift_mode = 1'b0; load_valid = 1'b1; shift_en = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      eb = v[7-i];
      checks++; if (qout !== eb) begin errors++; $display("FAIL abort_pre_bit%0d: got %b expected %b", i, qout, eb); end
      @(negedge clk);
    end
    checks++; if (qout !== 1'b0) begin errors++; $display("FAIL abort_bit4: got %b expected 0", qout); end
    #1 rst = 1'b0;
    #1;
    checks++; if (qout !== 1'b1) begin errors++; $display("FAIL abort_qout: got %b expected 1", qout); end
    checks++; if (qout_bar !== 1'b0) begin errors++; $display("FAIL abort_qout_bar: got %b expected 0", qout_bar); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL abort_last: got %b expected 0", last); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", load_ready); end
    @(negedge clk);
    rst = 1'b1;
    v = 8'h01;
    din = v; shift_mode = 1'b0; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      eb = v[7-i];
      checks++; if (qout !== eb) begin errors++; $display("FAIL abort_new_bit%0d: got %b expected %b", i, qout, eb); end
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_new_idle: got %b expected 0", busy); end
  endtask

`ifdef PISO_PARITY_EN
  task test_parity;
    logic [8:0] exp_q;
    logic       el;
    exp_q = 9'b111100000;      // 0,0,0,0,0,1,1,1 then even parity 1
    din = 8'h07; shift_mode = 1'b0; load_valid = 1'b1; shift_en = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      el = (i == 8);
      checks++; if (qout !== exp_q[i]) begin errors++; $display("FAIL par_bit%0d: got %b expected %b", i, qout, exp_q[i]); end
      checks++; if (last !== el) begin errors++; $display("FAIL par_last%0d: got %b expected %b", i, last, el); end
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL par_idle: got %b expected 0", busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_stall();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
